// File: rtl/imm_rot_encoder_if.sv
// Request/response bundle for the rotated-immediate encoder.
// The requester drives in_valid/in_value/out_ready; the encoder drives the rest.
interface imm_rot_encoder_if;
    logic        in_valid;
    logic [31:0] in_value;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        out_ok;
    logic [11:0] out_imm12;

    modport master (
        output in_valid, in_value, out_ready,
        input  in_ready, out_valid, out_ok, out_imm12
    );

    modport slave (
        input  in_valid, in_value, out_ready,
        output in_ready, out_valid, out_ok, out_imm12
    );
endinterface

// File: rtl/imm_rot_encoder.sv
// Sequential encoder for ARM rotated immediates: finds the lowest rot with
// value == ROR(imm8, 2*rot), testing STEPS rotations per SEARCH cycle.
module imm_rot_encoder #(
    parameter int STEPS = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    imm_rot_encoder_if.slave   bus
);

    generate
        if (!(STEPS == 1 || STEPS == 2 || STEPS == 4 || STEPS == 8 || STEPS == 16)) begin : g_bad_steps
            $error("imm_rot_encoder: STEPS must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam logic [4:0] STEP5 = 5'(STEPS);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] value_q, value_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        ok_q,    ok_d;
    logic [11:0] imm_q,   imm_d;

    logic        found;
    logic [3:0]  hit_rot;
    logic [7:0]  hit_imm;
    logic        last_group;

    // Rotate left modulo 32; a zero amount shifts the right half out entirely.
    function automatic logic [31:0] rol(input logic [31:0] v, input logic [4:0] sh);
        return (v << sh) | (v >> (6'd32 - {1'b0, sh}));
    endfunction

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
            value_q <= '0;
            cnt_q   <= '0;
            ok_q    <= 1'b0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            cnt_q   <= cnt_d;
            ok_q    <= ok_d;
            imm_q   <= imm_d;
        end
    end

    // Scan the group from the top down so the lowest matching rotation is written last.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        found   = 1'b0;
        hit_rot = '0;
        hit_imm = '0;
        for (int i = STEPS - 1; i >= 0; i--) begin
            if (rol(value_q, {cnt_q + 4'(i), 1'b0}) < 32'd256) begin
                found   = 1'b1;
                hit_rot = cnt_q + 4'(i);
                hit_imm = rol(value_q, {cnt_q + 4'(i), 1'b0}) & 32'hFF;
            end
        end
    end

    assign last_group = ({1'b0, cnt_q} + STEP5) == 5'd16;

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        cnt_d   = cnt_q;
        ok_d    = ok_q;
        imm_d   = imm_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = SEARCH;
                    value_d = bus.in_value;
                    cnt_d   = '0;
                end
            end
            SEARCH: begin
                if (found) begin
                    ok_d    = 1'b1;
                    imm_d   = {hit_rot, hit_imm};
                    state_d = DONE;
                end else if (last_group) begin
                    ok_d    = 1'b0;
                    imm_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + STEP5[3:0];
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    ok_d    = 1'b0;
                    imm_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_ok    = ok_q;
    assign bus.out_imm12 = imm_q;

endmodule

// File: tb/tb_imm_rot_encoder.sv
// Self-checking bench: STEPS=1 and STEPS=4 encoders share one request stream and
// are compared against a brute-force search over all sixteen rotations.
module tb_imm_rot_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_value = '0;
    logic        out_ready = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imm_rot_encoder_if bus1 ();
    imm_rot_encoder_if bus4 ();

    assign bus1.in_valid  = in_valid;
    assign bus1.in_value  = in_value;
    assign bus1.out_ready = out_ready;
    assign bus4.in_valid  = in_valid;
    assign bus4.in_value  = in_value;
    assign bus4.out_ready = out_ready;

    imm_rot_encoder #(.STEPS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    imm_rot_encoder #(.STEPS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [7:0] imm8, input logic [3:0] rot);
        logic [63:0] y;
        y = {56'd0, imm8} << (32 - 2 * int'(rot));
        return y[31:0] | y[63:32];
    endfunction

    // Try every rotation in order; the first that leaves a byte is the canonical one.
    task automatic model(input logic [31:0] v, input int steps,
                         output logic ok, output logic [11:0] imm, output int k);
        logic [63:0] x;
        logic [31:0] rotated;
        ok  = 1'b0;
        imm = '0;
        k   = 16 / steps;
        for (int r = 0; r < 16; r++) begin
            x       = {32'd0, v} << (2 * r);
            rotated = x[31:0] | x[63:32];
            if (!ok && rotated < 32'd256) begin
                ok  = 1'b1;
                imm = {4'(r), rotated[7:0]};
                k   = r / steps + 1;
            end
        end
    endtask

    task automatic txn(input logic [31:0] v, output logic ok1, output logic [11:0] imm1, output int k1);
        logic ok4, eok;
        logic [11:0] imm4, eimm;
        int k4, ek;
        bit leak;
        k1 = -1; k4 = -1; ok1 = 1'b0; imm1 = '0; ok4 = 1'b0; imm4 = '0; leak = 1'b0;
        @(negedge clk);
        check("ready1_before", bus1.in_ready, 1);
        check("ready4_before", bus4.in_ready, 1);
        in_valid = 1'b1;
        in_value = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_value = $urandom;
        for (int c = 1; c <= 20 && (k1 < 0 || k4 < 0); c++) begin
            @(posedge clk); #1;
            if (bus1.out_valid && k1 < 0) begin
                k1 = c; ok1 = bus1.out_ok; imm1 = bus1.out_imm12;
            end else if (!bus1.out_valid && (bus1.out_ok || bus1.out_imm12 != 0)) leak = 1'b1;
            if (bus4.out_valid && k4 < 0) begin
                k4 = c; ok4 = bus4.out_ok; imm4 = bus4.out_imm12;
            end else if (!bus4.out_valid && (bus4.out_ok || bus4.out_imm12 != 0)) leak = 1'b1;
        end
        model(v, 1, eok, eimm, ek);
        check("ok_s1", ok1, eok);
        check("imm_s1", imm1, eimm);
        check("lat_s1", k1, ek);
        model(v, 4, eok, eimm, ek);
        check("ok_s4", ok4, eok);
        check("imm_s4", imm4, eimm);
        check("lat_s4", k4, ek);
        check("outputs_zero_when_invalid", leak, 0);
        @(posedge clk); #1;
    endtask

    localparam int ND = 6;
    logic [31:0] d_val [ND] = '{32'h000000FF, 32'hFF000000, 32'hC000003F,
                                32'h00000101, 32'h00000000, 32'h0003FC00};
    logic [11:0] d_imm [ND] = '{12'h0FF, 12'h4FF, 12'h1FF, 12'h000, 12'h000, 12'hBFF};
    logic        d_ok  [ND] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int          d_k   [ND] = '{1, 5, 2, 16, 1, 12};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ok1;
        logic [11:0] imm1;
        int          k1;
        logic [7:0]  imm8;
        logic [3:0]  rot;
        logic [31:0] v;
        int          waited;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus1.in_ready, 1);
        check("rst_out_valid", bus1.out_valid, 0);
        check("rst_out_ok", bus1.out_ok, 0);
        check("rst_out_imm12", bus1.out_imm12, 0);
        check("rst_in_ready_s4", bus4.in_ready, 1);
        check("rst_out_valid_s4", bus4.out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < ND; i++) begin
            txn(d_val[i], ok1, imm1, k1);
            check("dir_ok", ok1, d_ok[i]);
            check("dir_imm", imm1, d_imm[i]);
            check("dir_lat", k1, d_k[i]);
        end

        // Backpressure: result held in DONE while another request waits.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_value  = 32'hFF000000;
        @(posedge clk); #1;
        in_value = 32'h000000FF;
        waited = 0;
        while (!bus1.out_valid && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("bp_reached_done", bus1.out_valid, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid_held", bus1.out_valid, 1);
            check("bp_ok_held", bus1.out_ok, 1);
            check("bp_imm_held", bus1.out_imm12, 12'h4FF);
            check("bp_no_accept", bus1.in_ready, 0);
            check("bp_s4_imm_held", bus4.out_imm12, 12'h4FF);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_idle", bus1.in_ready, 1);
        check("bp_release_valid", bus1.out_valid, 0);
        check("bp_release_ok_clr", bus1.out_ok, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_pending_accepted", bus1.in_ready, 0);
        @(posedge clk); #1;
        check("bp_next_valid", bus1.out_valid, 1);
        check("bp_next_imm", bus1.out_imm12, 12'h0FF);
        @(posedge clk); #1;
        check("bp_back_idle", bus1.in_ready, 1);

        // Reset in the middle of a long search.
        @(negedge clk);
        in_valid = 1'b1;
        in_value = 32'h00000101;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_in_ready", bus1.in_ready, 1);
        check("midrst_out_valid", bus1.out_valid, 0);
        check("midrst_out_ok", bus1.out_ok, 0);
        check("midrst_s4_in_ready", bus4.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 1000; i++) begin
            imm8 = 8'($urandom_range(0, 255));
            rot  = 4'($urandom_range(0, 15));
            v    = ror(imm8, rot);
            txn(v, ok1, imm1, k1);
            check("rnd_decode", ror(imm1[7:0], imm1[11:8]), v);
        end
        for (int i = 0; i < 100; i++) begin
            txn($urandom, ok1, imm1, k1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
